// File: rtl/rggen_indirect_access_pkg.sv
// Shared FSM state type for the indirect access sequencer.
// Latency: n/a (type definitions only).
// Backpressure: n/a.
package rggen_indirect_access_pkg;

  // Sequencer phases: wait for request, write index register,
  // access data register, present response.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INDEX = 2'd1,
    ST_DATA  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/rggen_indirect_access_sequencer.sv
// Turns one indexed request into an index-register write plus a data-register access, skipping the index write on a cache hit.
// Latency: response 3 cycles after accept on a miss, 2 on a hit, with zero-wait bus acks.
// Backpressure: one request in flight; o_req_ready only in IDLE, bus held until ack, response held until i_rsp_ready.
module rggen_indirect_access_sequencer
  import rggen_indirect_access_pkg::*;
#(
  parameter int                     ADDRESS_WIDTH = 16,
  parameter int                     DATA_WIDTH    = 32,
  parameter int                     INDEX_WIDTH   = 8,
  parameter logic [ADDRESS_WIDTH-1:0] INDEX_ADDRESS = '0,
  parameter logic [ADDRESS_WIDTH-1:0] DATA_ADDRESS  = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic                     i_req_write,
  input  logic [INDEX_WIDTH-1:0]   i_req_index,
  input  logic [DATA_WIDTH-1:0]    i_req_data,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [DATA_WIDTH-1:0]    o_rsp_data,
  output logic                     o_rsp_error,
  output logic                     o_bus_valid,
  output logic                     o_bus_write,
  output logic [ADDRESS_WIDTH-1:0] o_bus_address,
  output logic [DATA_WIDTH-1:0]    o_bus_write_data,
  input  logic                     i_bus_ack,
  input  logic                     i_bus_error,
  input  logic [DATA_WIDTH-1:0]    i_bus_read_data,
  input  logic                     i_cache_clear
);

  state_e                   state;
  logic                     req_write;
  logic [INDEX_WIDTH-1:0]   req_index;
  logic [DATA_WIDTH-1:0]    req_data;
  logic [DATA_WIDTH-1:0]    rsp_data;
  logic                     rsp_error;
  logic                     cache_valid;
  logic [INDEX_WIDTH-1:0]   cached_index;
  logic                     req_accept;
  logic                     cache_hit;
  logic                     index_ack_ok;
  logic                     bus_ack_err;
  logic [DATA_WIDTH-1:0]    index_ext;

  assign req_accept   = i_req_valid && (state == ST_IDLE);
  assign cache_hit    = cache_valid && (cached_index == i_req_index);
  assign index_ack_ok = (state == ST_INDEX) && i_bus_ack && !i_bus_error;
  assign bus_ack_err  = ((state == ST_INDEX) || (state == ST_DATA)) && i_bus_ack && i_bus_error;

  // Ready is gated by reset so it reads 0 while rst_n is held low.
  assign o_req_ready = rst_n && (state == ST_IDLE);
  assign o_rsp_valid = (state == ST_RESP);
  assign o_rsp_data  = rsp_data;
  assign o_rsp_error = rsp_error;

  // Zero-extend the captured index onto the data bus.
  always_comb begin
    index_ext                  = '0;
    index_ext[INDEX_WIDTH-1:0] = req_index;
  end

  // Bus outputs decode purely from state and captured registers, so they stay stable until ack.
  always_comb begin
    o_bus_valid      = 1'b0;
    o_bus_write      = 1'b0;
    o_bus_address    = '0;
    o_bus_write_data = '0;
    case (state)
      ST_INDEX: begin
        o_bus_valid      = 1'b1;
        o_bus_write      = 1'b1;
        o_bus_address    = INDEX_ADDRESS;
        o_bus_write_data = index_ext;
      end
      ST_DATA: begin
        o_bus_valid      = 1'b1;
        o_bus_write      = req_write;
        o_bus_address    = DATA_ADDRESS;
        o_bus_write_data = req_data;
      end
      default: ;
    endcase
  end

  // Sequencer FSM plus request capture and response capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      req_write <= 1'b0;
      req_index <= '0;
      req_data  <= '0;
      rsp_data  <= '0;
      rsp_error <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_accept) begin
            req_write <= i_req_write;
            req_index <= i_req_index;
            req_data  <= i_req_data;
            state     <= cache_hit ? ST_DATA : ST_INDEX;
          end
        end
        ST_INDEX: begin
          if (i_bus_ack) begin
            if (i_bus_error) begin
              rsp_data  <= '0;
              rsp_error <= 1'b1;
              state     <= ST_RESP;
            end else begin
              state     <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (i_bus_ack) begin
            rsp_data  <= req_write ? '0 : i_bus_read_data;
            rsp_error <= i_bus_error;
            state     <= ST_RESP;
          end
        end
        default: begin
          if (i_rsp_ready) begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Index cache: an external clear beats a fill on the same cycle; any bus error invalidates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_valid <= 1'b0;
    end else if (i_cache_clear) begin
      cache_valid <= 1'b0;
    end else if (index_ack_ok) begin
      cache_valid <= 1'b1;
    end else if (bus_ack_err) begin
      cache_valid <= 1'b0;
    end
  end

  // Remember which index the hardware index register currently holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cached_index <= '0;
    end else if (index_ack_ok) begin
      cached_index <= req_index;
    end
  end

endmodule

// File: tb/tb_rggen_indirect_access_sequencer.sv
// Directed and randomized checks of the indirect access sequencer against a cache/bus-sequence model.
// Latency: measured per transaction against the expected miss/hit cycle counts.
// Backpressure: bus responder inserts wait states; response ready is held low on chosen transactions.
module tb_rggen_indirect_access_sequencer;

  localparam logic [15:0] IDX_ADDR = 16'h0010;
  localparam logic [15:0] DAT_ADDR = 16'h0014;

  typedef struct packed {
    logic        w;
    logic [15:0] a;
    logic [31:0] d;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req_valid, o_req_ready, i_req_write;
  logic [7:0]  i_req_index;
  logic [31:0] i_req_data;
  logic        o_rsp_valid, i_rsp_ready, o_rsp_error;
  logic [31:0] o_rsp_data;
  logic        o_bus_valid, o_bus_write;
  logic [15:0] o_bus_address;
  logic [31:0] o_bus_write_data;
  logic        i_bus_ack, i_bus_error;
  logic [31:0] i_bus_read_data;
  logic        i_cache_clear;

  int checks = 0;
  int errors = 0;

  // Responder configuration, written by the stimulus process.
  int          cfg_delay = 0;
  logic        cfg_ie = 1'b0;
  logic        cfg_de = 1'b0;
  logic [31:0] cfg_rd = '0;
  logic        cfg_clr = 1'b0;
  acc_t        bus_log[$];

  // Reference model: what the hardware index register is known to hold.
  logic        m_cv = 1'b0;
  logic [7:0]  m_ci = '0;

  always #5 clk = ~clk;

  rggen_indirect_access_sequencer #(
    .ADDRESS_WIDTH (16),
    .DATA_WIDTH    (32),
    .INDEX_WIDTH   (8),
    .INDEX_ADDRESS (IDX_ADDR),
    .DATA_ADDRESS  (DAT_ADDR)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_req_valid      (i_req_valid),
    .o_req_ready      (o_req_ready),
    .i_req_write      (i_req_write),
    .i_req_index      (i_req_index),
    .i_req_data       (i_req_data),
    .o_rsp_valid      (o_rsp_valid),
    .i_rsp_ready      (i_rsp_ready),
    .o_rsp_data       (o_rsp_data),
    .o_rsp_error      (o_rsp_error),
    .o_bus_valid      (o_bus_valid),
    .o_bus_write      (o_bus_write),
    .o_bus_address    (o_bus_address),
    .o_bus_write_data (o_bus_write_data),
    .i_bus_ack        (i_bus_ack),
    .i_bus_error      (i_bus_error),
    .i_bus_read_data  (i_bus_read_data),
    .i_cache_clear    (i_cache_clear)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bus slave: acks after cfg_delay wait cycles, logs every completed access, checks hold stability.
  initial begin : responder
    int   wcnt;
    acc_t snap;
    acc_t cur;
    wcnt = 0;
    snap = '0;
    i_bus_ack = 1'b0;
    i_bus_error = 1'b0;
    i_bus_read_data = '0;
    i_cache_clear = 1'b0;
    forever begin
      @(negedge clk);
      i_bus_ack       = 1'b0;
      i_bus_error     = 1'b0;
      i_bus_read_data = $urandom;
      i_cache_clear   = 1'b0;
      if (!o_bus_valid) begin
        wcnt = 0;
      end else begin
        cur = acc_t'({o_bus_write, o_bus_address, o_bus_write_data});
        if (wcnt == 0) snap = cur;
        else check("bus_hold_stable", 64'(cur), 64'(snap));
        if (wcnt >= cfg_delay) begin
          i_bus_ack       = 1'b1;
          i_bus_error     = (o_bus_address == IDX_ADDR) ? cfg_ie : cfg_de;
          i_bus_read_data = cfg_rd;
          i_cache_clear   = (o_bus_address == IDX_ADDR) && cfg_clr;
          bus_log.push_back(cur);
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end
    end
  end

  // One complete transaction. Called at #1 after a rising edge with the DUT idle.
  task automatic do_req(input logic wr, input logic [7:0] idx, input logic [31:0] dat,
                        input logic ie, input logic de, input logic [31:0] rd,
                        input int dly, input int hold, input logic clr, input string tag);
    acc_t        exp_q[$];
    logic        hit;
    logic [31:0] e_data;
    logic        e_err;
    int          e_lat;
    int          lat;
    bit          got;
    cfg_delay = dly; cfg_ie = ie; cfg_de = de; cfg_rd = rd; cfg_clr = clr;
    bus_log.delete();
    // Model: index write on a miss, then data access unless the index write failed.
    hit = m_cv && (m_ci == idx);
    if (!hit) exp_q.push_back(acc_t'({1'b1, IDX_ADDR, {24'd0, idx}}));
    if (!hit && ie) begin
      e_data = '0; e_err = 1'b1; m_cv = 1'b0; e_lat = 2;
    end else begin
      exp_q.push_back(acc_t'({wr, DAT_ADDR, dat}));
      e_data = wr ? 32'd0 : rd;
      e_err  = de;
      e_lat  = hit ? 2 : 3;
      if (!hit) begin m_cv = !clr; m_ci = idx; end
      if (de) m_cv = 1'b0;
    end
    i_req_valid = 1'b1; i_req_write = wr; i_req_index = idx; i_req_data = dat;
    check({tag, "_req_ready"}, 64'(o_req_ready), 64'(1));
    @(posedge clk); #1;
    i_req_valid = 1'b0; i_req_data = $urandom; i_req_index = 8'($urandom);
    check({tag, "_busy"}, 64'(o_req_ready), 64'(0));
    lat = 1; got = 0;
    for (int n = 0; n < 200; n++) begin
      if (o_rsp_valid) begin got = 1; break; end
      @(posedge clk); #1; lat++;
    end
    if (!got) begin
      check({tag, "_rsp_timeout"}, 64'(0), 64'(1));
      return;
    end
    if (dly == 0) check({tag, "_latency"}, 64'(lat), 64'(e_lat));
    for (int h = 0; h <= hold; h++) begin
      check({tag, "_rsp_valid"}, 64'(o_rsp_valid), 64'(1));
      check({tag, "_rsp_data"},  64'(o_rsp_data),  64'(e_data));
      check({tag, "_rsp_error"}, 64'(o_rsp_error), 64'(e_err));
      check({tag, "_ready_low"}, 64'(o_req_ready), 64'(0));
      if (h < hold) begin @(posedge clk); #1; end
    end
    i_rsp_ready = 1'b1;
    @(posedge clk); #1;
    i_rsp_ready = 1'b0;
    check({tag, "_rsp_done"},  64'(o_rsp_valid), 64'(0));
    check({tag, "_ready_back"}, 64'(o_req_ready), 64'(1));
    check({tag, "_bus_count"}, 64'(bus_log.size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < bus_log.size(); k++)
      check({tag, "_bus_access"}, 64'(bus_log[k]), 64'(exp_q[k]));
    cfg_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; i_req_valid = 1'b0; i_req_write = 1'b0; i_req_index = '0;
    i_req_data = '0; i_rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(o_req_ready), 64'(0));
    check("rst_rsp_valid", 64'(o_rsp_valid), 64'(0));
    check("rst_rsp_data",  64'(o_rsp_data),  64'(0));
    check("rst_rsp_error", 64'(o_rsp_error), 64'(0));
    check("rst_bus",       64'({o_bus_valid, o_bus_write, o_bus_address, o_bus_write_data}), 64'(0));
    rst_n = 1'b1;
    #1;
    check("release_ready", 64'(o_req_ready), 64'(1));
    @(posedge clk); #1;

    // Cold read, then a hit write on the same index.
    do_req(1'b0, 8'd5, 32'h0, 1'b0, 1'b0, 32'h1234_5678, 0, 0, 1'b0, "cold_read");
    do_req(1'b1, 8'd5, 32'hA5A5_A5A5, 1'b0, 1'b0, 32'hDEAD_BEEF, 0, 0, 1'b0, "hit_write");
    // Index error, then the same index must re-write the index register.
    do_req(1'b0, 8'd7, 32'h0, 1'b1, 1'b0, 32'h1111_2222, 0, 0, 1'b0, "index_err");
    do_req(1'b0, 8'd7, 32'h0, 1'b0, 1'b0, 32'h3333_4444, 0, 0, 1'b0, "index_retry");
    // Wait-state bus with a slow response consumer.
    do_req(1'b0, 8'd12, 32'h0, 1'b0, 1'b0, 32'hCAFE_F00D, 4, 3, 1'b0, "wait_read");
    do_req(1'b1, 8'd12, 32'h0BAD_CAFE, 1'b0, 1'b0, 32'h0, 4, 3, 1'b0, "wait_write");
    // Data error invalidates the cache.
    do_req(1'b0, 8'd12, 32'h0, 1'b0, 1'b1, 32'h5555_AAAA, 0, 0, 1'b0, "data_err");
    do_req(1'b0, 8'd12, 32'h0, 1'b0, 1'b0, 32'h6666_7777, 0, 0, 1'b0, "after_derr");
    // Clear coinciding with a successful index ack.
    do_req(1'b0, 8'd9, 32'h0, 1'b0, 1'b0, 32'h9999_0000, 0, 0, 1'b1, "clear_collide");
    do_req(1'b0, 8'd9, 32'h0, 1'b0, 1'b0, 32'h0000_9999, 0, 0, 1'b0, "clear_retry");

    // Mid-operation reset during a stalled data access.
    do_req(1'b0, 8'h21, 32'h0, 1'b0, 1'b0, 32'h2121_2121, 0, 0, 1'b0, "pre_reset");
    cfg_delay = 20; cfg_ie = 1'b0; cfg_de = 1'b0; cfg_clr = 1'b0;
    bus_log.delete();
    i_req_valid = 1'b1; i_req_write = 1'b1; i_req_index = 8'h21; i_req_data = 32'h7777_8888;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("mid_in_data", 64'({o_bus_valid, o_bus_address}), 64'({1'b1, DAT_ADDR}));
    rst_n = 1'b0;
    #1;
    m_cv = 1'b0;
    check("mid_rst_ready", 64'(o_req_ready), 64'(0));
    check("mid_rst_rsp",   64'({o_rsp_valid, o_rsp_error, o_rsp_data}), 64'(0));
    check("mid_rst_bus",   64'({o_bus_valid, o_bus_write, o_bus_address, o_bus_write_data}), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("mid_release_ready", 64'(o_req_ready), 64'(1));
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("mid_no_rsp", 64'(o_rsp_valid), 64'(0));
    end
    check("mid_no_bus", 64'(bus_log.size()), 64'(0));
    do_req(1'b0, 8'h21, 32'h0, 1'b0, 1'b0, 32'h4242_4242, 0, 0, 1'b0, "post_reset");

    // Randomized traffic over a small index set so hits and misses both occur.
    for (int t = 0; t < 40; t++) begin
      do_req(1'($urandom_range(0, 1)), 8'($urandom_range(0, 3)), $urandom,
             1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0), $urandom,
             $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom_range(0, 9) == 0), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rggen_indirect_access_sequencer.md
RGGEN_INDIRECT_ACCESS_SEQUENCER -- requirements
Module: rggen_indirect_access_sequencer

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 16: register bus address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: register bus data width.
REQ-003 SHALL have parameter INDEX_WIDTH, default 8: index width, with INDEX_WIDTH <= DATA_WIDTH.
REQ-004 SHALL have parameter INDEX_ADDRESS, default '0: address of the index register.
REQ-005 SHALL have parameter DATA_ADDRESS, default '0: address of the indirect data register.
REQ-006 SHALL have port clk  input  1  clock; one clock domain, all logic on rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have request ports: i_req_valid in 1; o_req_ready out 1; i_req_write in 1; i_req_index in INDEX_WIDTH; i_req_data in DATA_WIDTH.
REQ-009 SHALL have response ports: o_rsp_valid out 1; i_rsp_ready in 1; o_rsp_data out DATA_WIDTH; o_rsp_error out 1.
REQ-010 SHALL have bus ports: o_bus_valid out 1; o_bus_write out 1; o_bus_address out ADDRESS_WIDTH; o_bus_write_data out DATA_WIDTH.
REQ-011 SHALL have bus return ports: i_bus_ack in 1; i_bus_error in 1 (valid with ack); i_bus_read_data in DATA_WIDTH (valid with ack).
REQ-012 SHALL have port i_cache_clear  input  1  invalidates the cached index.

Function
REQ-013 SHALL implement FSM states IDLE, INDEX, DATA, RESP.
REQ-014 SHALL drive o_req_ready=1 only in IDLE; accept a request on i_req_valid&&o_req_ready and capture write, index and data.
REQ-015 SHALL, on accept, go to DATA if cache_valid and the captured index equals cached_index; otherwise go to INDEX.
REQ-016 SHALL, in INDEX, drive o_bus_valid=1, o_bus_write=1, o_bus_address=INDEX_ADDRESS, o_bus_write_data=index zero-extended to DATA_WIDTH.
REQ-017 SHALL, on INDEX ack without error, set cache_valid=1 and cached_index=index, then go to DATA.
REQ-018 SHALL, on INDEX ack with error, clear cache_valid, set error=1, skip DATA and go to RESP.
REQ-019 SHALL, in DATA, drive o_bus_valid=1, o_bus_write=captured write, o_bus_address=DATA_ADDRESS, o_bus_write_data=captured data.
REQ-020 SHALL, on DATA ack, capture i_bus_read_data for reads (0 for writes) and i_bus_error, then go to RESP.
REQ-021 SHALL clear cache_valid on a DATA error; cached_index is retained but unused.
REQ-022 SHALL hold all o_bus_* outputs stable while o_bus_valid=1 and i_bus_ack=0, and drive o_bus_valid=0 in IDLE and RESP.
REQ-023 SHALL, in RESP, drive o_rsp_valid=1 with stable o_rsp_data and o_rsp_error until i_rsp_ready=1, then go to IDLE.
REQ-024 SHALL permit a zero-wait ack, i.e. an ack in the first cycle of INDEX or DATA.
REQ-025 SHALL give latency from accept edge to o_rsp_valid of 3 cycles on a cache miss and 2 cycles on a hit, with zero-wait acks.
REQ-026 SHALL clear cache_valid when i_cache_clear=1 in any state.
REQ-027 SHALL let a clear win when i_cache_clear=1 coincides with a successful INDEX ack; the request still proceeds to DATA.
REQ-028 SHALL ignore i_bus_ack in IDLE and RESP.

Reset
REQ-029 SHALL, while rst_n=0, force state=IDLE, cache_valid=0, cached_index=0 and all captured registers to 0.
REQ-030 SHALL, in reset, drive o_req_ready=0, o_rsp_valid=0, o_rsp_data=0, o_rsp_error=0, o_bus_valid=0, o_bus_write=0, o_bus_address=0 and o_bus_write_data=0.
REQ-031 SHALL abandon any in-flight transfer when reset is asserted mid-operation, with no response issued after release.
REQ-032 SHALL assert o_req_ready in the first cycle after release.

Structure
REQ-033 SHALL take the FSM state enum (2-bit) from package rggen_indirect_access_pkg.
REQ-034 SHALL be flat with no sub-module; the index cache is a register plus comparator inside the module.

Verification
REQ-035 SHALL cover a cold read: write=0, index=5, zero-wait acks, bus rdata=0x1234_5678 -> bus write 0x5 to INDEX_ADDRESS, then read DATA_ADDRESS; rsp data=0x12345678, error=0, 3 cycles.
REQ-036 SHALL cover a cache hit: repeat index=5 as a write of 0xA5A5_A5A5 -> no INDEX access, single bus write of 0xA5A5A5A5 to DATA_ADDRESS; rsp 2 cycles after accept.
REQ-037 SHALL cover an INDEX error: index=7, ack with error=1 -> no DATA access, rsp error=1, data=0; next index=7 request performs an INDEX write again.
REQ-038 SHALL cover a wait-state bus with 4-cycle ack delay and i_rsp_ready low for 3 cycles -> bus outputs and rsp outputs stable throughout; o_req_ready=0 until the handshake.
REQ-039 SHALL cover a clear collision: i_cache_clear pulsed on the INDEX ack cycle for index=9 -> DATA proceeds; next index=9 request re-issues the INDEX write.
REQ-040 SHALL cover mid-operation reset: rst_n low during DATA wait -> all outputs 0 immediately; after release o_req_ready=1, no rsp, and the first request re-writes the index.
